traffic_light_monitor: RTL and testbench

//   Receive-side checker for the traffic light controller's lamp outputs (red/yellow/green).

---
 rtl/traffic_light_monitor.sv | 165 ++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Passive checker for traffic light lamp outputs. It tracks the observed phase
// and how long it lasts, and reports illegal lamps, bad transitions and dwell violations.
module traffic_light_monitor #(
    parameter int CNT_W      = 8,
    parameter int ERR_W      = 8,
    parameter int RED_MIN    = 4,
    parameter int RED_MAX    = 40,
    parameter int GREEN_MIN  = 4,
    parameter int GREEN_MAX  = 24,
    parameter int YELLOW_MIN = 2,
    parameter int YELLOW_MAX = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             red,
    input  logic             yellow,
    input  logic             green,
    input  logic             clr_count,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] last_dwell,
    output logic             err_valid,
    output logic [2:0]       err_code,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [1:0] {
        SYNC   = 2'b00,
        RED    = 2'b01,
        GREEN  = 2'b10,
        YELLOW = 2'b11
    } phase_t;

    localparam logic [2:0] E_ILLEGAL = 3'd1;
    localparam logic [2:0] E_BAD_TR  = 3'd2;
    localparam logic [2:0] E_SHORT   = 3'd3;
    localparam logic [2:0] E_LONG    = 3'd4;

    phase_t           state_q, state_d, samp;
    logic [CNT_W-1:0] dwell_q, dwell_d, last_dwell_d;
    logic             first_q, first_d;
    logic             one_hot, err_d;
    logic [2:0]       code_d;
    logic [ERR_W-1:0] count_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] d);
        return (d == '1) ? d : d + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] dwell_min(input phase_t p);
        case (p)
            RED:     return CNT_W'(RED_MIN);
            GREEN:   return CNT_W'(GREEN_MIN);
            YELLOW:  return CNT_W'(YELLOW_MIN);
            default: return '0;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] dwell_max(input phase_t p);
        case (p)
            RED:     return CNT_W'(RED_MAX);
            GREEN:   return CNT_W'(GREEN_MAX);
            YELLOW:  return CNT_W'(YELLOW_MAX);
            default: return '1;
        endcase
    endfunction

    function automatic phase_t next_legal(input phase_t p);
        case (p)
            RED:     return GREEN;
            GREEN:   return YELLOW;
            YELLOW:  return RED;
            default: return SYNC;
        endcase
    endfunction

    always_comb begin
        samp    = SYNC;
        one_hot = 1'b1;
        case ({red, yellow, green})
            3'b100:  samp = RED;
            3'b010:  samp = YELLOW;
            3'b001:  samp = GREEN;
            default: one_hot = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        dwell_d      = dwell_q;
        first_d      = first_q;
        last_dwell_d = last_dwell;
        err_d        = 1'b0;
        code_d       = err_code;
        if (enable) begin
            if (state_q == SYNC) begin
                if (one_hot) begin
                    state_d = samp;
                    dwell_d = CNT_W'(1);
                end
            end else if (!one_hot) begin
                err_d   = 1'b1;
                code_d  = E_ILLEGAL;
                state_d = SYNC;
                first_d = 1'b1;
                dwell_d = '0;
            end else if (samp == state_q) begin
                dwell_d = sat_inc(dwell_q);
                // dwell_q == MAX means this sample is the first one past the limit
                if (dwell_q == dwell_max(state_q)) begin
                    err_d  = 1'b1;
                    code_d = E_LONG;
                end
            end else if (samp == next_legal(state_q)) begin
                last_dwell_d = dwell_q;
                state_d      = samp;
                dwell_d      = CNT_W'(1);
                first_d      = 1'b0;
                if (!first_q && (dwell_q < dwell_min(state_q))) begin
                    err_d  = 1'b1;
                    code_d = E_SHORT;
                end
            end else begin
                err_d        = 1'b1;
                code_d       = E_BAD_TR;
                last_dwell_d = dwell_q;
                state_d      = samp;
                dwell_d      = CNT_W'(1);
                first_d      = 1'b1;
            end
        end
    end

    always_comb begin
        if (clr_count)
            count_d = err_d ? ERR_W'(1) : '0;
        else if (err_d && (err_count != '1))
            count_d = err_count + 1'b1;
        else
            count_d = err_count;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SYNC;
            dwell_q    <= '0;
            first_q    <= 1'b1;
            last_dwell <= '0;
            err_valid  <= 1'b0;
            err_code   <= '0;
            err_count  <= '0;
        end else begin
            state_q    <= state_d;
            dwell_q    <= dwell_d;
            first_q    <= first_d;
            last_dwell <= last_dwell_d;
            err_valid  <= err_d;
            err_code   <= code_d;
            err_count  <= count_d;
        end
    end

    assign phase = state_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: the stimulus queues hand-computed
// expected outputs and a separate monitor compares them once the DUT has sampled.
module tb_traffic_light_monitor;

    localparam logic [2:0] L_R    = 3'b100;
    localparam logic [2:0] L_Y    = 3'b010;
    localparam logic [2:0] L_G    = 3'b001;
    localparam logic [2:0] L_RG   = 3'b101;
    localparam logic [2:0] L_ALL  = 3'b111;
    localparam logic [2:0] L_NONE = 3'b000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       red = 1'b0, yellow = 1'b0, green = 1'b0;
    logic       clr_count = 1'b0;
    logic [1:0] phase;
    logic [7:0] last_dwell;
    logic       err_valid;
    logic [2:0] err_code;
    logic [7:0] err_count;

    traffic_light_monitor dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .red        (red),
        .yellow     (yellow),
        .green      (green),
        .clr_count  (clr_count),
        .phase      (phase),
        .last_dwell (last_dwell),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         due;
        int         tag;
        logic [1:0] ph;
        logic [7:0] ld;
        logic       ev;
        logic [2:0] code;
        logic [7:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   tag_n = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            n_tests++;
            if (phase !== e.ph || last_dwell !== e.ld || err_valid !== e.ev ||
                err_code !== e.code || err_count !== e.cnt) begin
                n_fail++;
                $display("FAIL sample#%0d: got phase=%0d last_dwell=%0d err_valid=%0d err_code=%0d err_count=%0d, want phase=%0d last_dwell=%0d err_valid=%0d err_code=%0d err_count=%0d",
                         e.tag, phase, last_dwell, err_valid, err_code, err_count,
                         e.ph, e.ld, e.ev, e.code, e.cnt);
            end
        end
    end

    task automatic push_exp(input int due, input logic [1:0] ph, input int ld,
                            input logic ev, input logic [2:0] code, input int cnt);
        exp_t e;
        e.due  = due;
        e.tag  = tag_n;
        e.ph   = ph;
        e.ld   = 8'(ld);
        e.ev   = ev;
        e.code = code;
        e.cnt  = 8'(cnt);
        tag_n++;
        exp_q.push_back(e);
    endtask

    // One sample per call; expected outputs are due after the next rising edge.
    task automatic step(input logic [2:0] l, input logic en, input logic clr,
                        input logic [1:0] ph, input int ld, input logic ev,
                        input logic [2:0] code, input int cnt);
        @(posedge clk);
        #1;
        {red, yellow, green} = l;
        enable    = en;
        clr_count = clr;
        push_exp(cyc + 1, ph, ld, ev, code, cnt);
    endtask

    task automatic idle_drain();
        @(posedge clk);
        #1;
        enable    = 1'b0;
        clr_count = 1'b0;
        {red, yellow, green} = L_NONE;
        for (int k = 0; k < 50 && exp_q.size() > 0; k++) @(posedge clk);
        if (exp_q.size() != 0) begin
            $display("FAIL drain: %0d expected responses never checked, want 0", exp_q.size());
            $fatal(1, "scoreboard did not drain");
        end
    endtask

    initial begin
        // reset state, checked while reset is still held
        push_exp(0, 2'd0, 0, 1'b0, 3'd0, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // full legal cycle with no errors
        for (int i = 0; i < 34; i++) step(L_R, 1, 0, 2'd1, 0, 0, 3'd0, 0);
        for (int i = 0; i < 22; i++) step(L_G, 1, 0, 2'd2, 34, 0, 3'd0, 0);
        for (int i = 0; i < 9; i++)  step(L_Y, 1, 0, 2'd3, 22, 0, 3'd0, 0);
        step(L_R, 1, 0, 2'd1, 9, 0, 3'd0, 0);

        // illegal lamps, then resync on green
        step(L_RG, 1, 0, 2'd0, 9, 1, 3'd1, 1);
        step(L_G, 1, 0, 2'd2, 9, 0, 3'd1, 1);
        step(L_G, 1, 0, 2'd2, 9, 0, 3'd1, 1);

        // legal cycle then red -> yellow (bad transition)
        for (int i = 0; i < 4; i++)  step(L_G, 1, 0, 2'd2, 9, 0, 3'd1, 1);
        for (int i = 0; i < 3; i++)  step(L_Y, 1, 0, 2'd3, 6, 0, 3'd1, 1);
        for (int i = 0; i < 10; i++) step(L_R, 1, 0, 2'd1, 3, 0, 3'd1, 1);
        step(L_Y, 1, 0, 2'd3, 10, 1, 3'd2, 2);

        // yellow held to 15 samples: long-dwell error once, on the 11th
        for (int i = 2; i <= 15; i++)
            step(L_Y, 1, 0, 2'd3, 10, (i == 11), (i >= 11) ? 3'd4 : 3'd2, (i >= 11) ? 3 : 2);

        // red x10, green x2, yellow: short green dwell
        for (int i = 0; i < 10; i++) step(L_R, 1, 0, 2'd1, 15, 0, 3'd4, 3);
        step(L_G, 1, 0, 2'd2, 10, 0, 3'd4, 3);
        step(L_G, 1, 0, 2'd2, 10, 0, 3'd4, 3);
        step(L_Y, 1, 0, 2'd3, 2, 1, 3'd3, 4);

        // enable low mid-red holds dwell; red of exactly RED_MIN is legal
        step(L_Y, 1, 0, 2'd3, 2, 0, 3'd3, 4);
        step(L_Y, 1, 0, 2'd3, 2, 0, 3'd3, 4);
        step(L_R, 1, 0, 2'd1, 3, 0, 3'd3, 4);
        step(L_R, 1, 0, 2'd1, 3, 0, 3'd3, 4);
        step(L_R, 1, 0, 2'd1, 3, 0, 3'd3, 4);
        for (int i = 0; i < 5; i++) step(L_ALL, 0, 0, 2'd1, 3, 0, 3'd3, 4);
        step(L_R, 1, 0, 2'd1, 3, 0, 3'd3, 4);
        step(L_G, 1, 0, 2'd2, 4, 0, 3'd3, 4);

        // clr_count with a coincident error, then alone
        step(L_ALL, 1, 1, 2'd0, 4, 1, 3'd1, 1);
        step(L_NONE, 1, 1, 2'd0, 4, 0, 3'd1, 0);

        // bad transition then short red after it is not flagged
        step(L_G, 1, 0, 2'd2, 4, 0, 3'd1, 0);
        step(L_G, 1, 0, 2'd2, 4, 0, 3'd1, 0);
        step(L_R, 1, 0, 2'd1, 2, 1, 3'd2, 1);
        step(L_G, 1, 0, 2'd2, 1, 0, 3'd2, 1);
        idle_drain();

        // asynchronous reset mid-green
        @(posedge clk);
        #3;
        reset = 1'b1;
        push_exp(cyc, 2'd0, 0, 1'b0, 3'd0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // error counter saturates at all-ones
        for (int i = 0; i < 260; i++) begin
            step(L_R, 1, 0, 2'd1, 0, 0, (i == 0) ? 3'd0 : 3'd1, (i > 255) ? 255 : i);
            step(L_ALL, 1, 0, 2'd0, 0, 1, 3'd1, (i + 1 > 255) ? 255 : i + 1);
        end
        idle_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
